alu_issue_ctrl: RTL and testbench

- Issue controller between IDU1 and the ALU.
- Buffers decoded instructions in a small in-order queue and drives one ALU control word per cycle.
- Keeps queued source operands current by capturing ALU writebacks.
- Stalls issue behind each control-transfer instruction until the ALU reports redirect status, and flushes wrong-path entries on a taken redirect.

---
 rtl/alu_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller between IDU1 and the ALU: in-order queue, writeback capture and branch-resolution stall.
// Define ALU_ISSUE_FWD_EN to forward ALU writebacks into the head; the default build stalls one cycle on RAW hazards.
package alu_issue_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            rs2;
    logic [4:0]      rd_addr;
    logic            rd;
    logic            jal;
    logic            condbr;
    logic            alu;
    logic            legal;
    logic            nop;
  } idu1_out_t;
endpackage

module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  idu1_out_t       in_ctrl,
  output idu1_out_t       alu_ctrl,
  input  logic [XLEN-1:0] alu_wb_data,
  input  logic [4:0]      alu_wb_rd_addr,
  input  logic            alu_wb_rd_wr_en,
  input  logic            pc_load,
  output logic            busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    ST_RUN,
    ST_BR_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  idu1_out_t       entry_q [DEPTH];
  idu1_out_t       entry_d [DEPTH];

  idu1_out_t       head;
  idu1_out_t       head_fwd;
  logic            wb_hit;
  logic            empty;
  logic            hazard;
  logic            issue;
  logic            enq;
  logic            flush;
  logic            head_is_ctrl;

  // Same address-match rule serves queue capture, enqueue override and head forwarding.
  function automatic idu1_out_t apply_wb(input idu1_out_t e, input logic hit,
                                         input logic [4:0] addr, input logic [XLEN-1:0] data);
    idu1_out_t r;
    r = e;
    if (hit && e.rs1_addr == addr) r.rs1_data = data;
    if (hit && e.rs2 && e.rs2_addr == addr) r.rs2_data = data;
    return r;
  endfunction

  assign wb_hit       = alu_wb_rd_wr_en && (alu_wb_rd_addr != 5'd0);
  assign head         = entry_q[rd_ptr_q];
  assign empty        = (count_q == '0);
  assign in_ready     = (count_q < CW'(DEPTH));
  assign busy         = !empty || (state_q == ST_BR_WAIT);
  assign enq          = in_valid && in_ready;
  assign flush        = (state_q == ST_BR_WAIT) && pc_load;
  assign head_is_ctrl = (head.jal || head.condbr) && head.legal && head.alu && !head.nop;
  assign issue        = !rst && !empty && (state_q == ST_RUN) && !hazard;

`ifdef ALU_ISSUE_FWD_EN
  assign hazard   = 1'b0;
  assign head_fwd = apply_wb(head, wb_hit, alu_wb_rd_addr, alu_wb_data);
`else
  logic       prev_rd_vld_q, prev_rd_vld_d;
  logic [4:0] prev_rd_addr_q, prev_rd_addr_d;

  // prev_rd_vld already implies a non-zero destination, so x0 sources never match.
  assign hazard = prev_rd_vld_q &&
                  ((head.rs1_addr == prev_rd_addr_q) ||
                   (head.rs2 && (head.rs2_addr == prev_rd_addr_q)));
  assign head_fwd = head;

  always_comb begin
    prev_rd_vld_d  = issue && head.rd && head.legal && head.alu && !head.nop &&
                     (head.rd_addr != 5'd0);
    prev_rd_addr_d = head.rd_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_rd_vld_q  <= 1'b0;
      prev_rd_addr_q <= 5'd0;
    end else begin
      prev_rd_vld_q  <= prev_rd_vld_d;
      prev_rd_addr_q <= prev_rd_addr_d;
    end
  end
`endif

  always_comb begin
    alu_ctrl     = '0;
    alu_ctrl.nop = 1'b1;
    if (issue) alu_ctrl = head_fwd;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (issue && head_is_ctrl) state_d = ST_BR_WAIT;
      ST_BR_WAIT: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  // A taken redirect drops every queued entry as well as this cycle's enqueue.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = apply_wb(entry_q[i], wb_hit, alu_wb_rd_addr, alu_wb_data);
      if (enq && !flush && (PW'(i) == wr_ptr_q))
        entry_d[i] = apply_wb(in_ctrl, wb_hit, alu_wb_rd_addr, alu_wb_data);
    end
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (issue) rd_ptr_d = rd_ptr_q + PW'(1);
      if (enq)   wr_ptr_d = wr_ptr_q + PW'(1);
      case ({enq, issue})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: program-order reference model plus a behavioural ALU driving writebacks/redirects.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  idu1_out_t       in_ctrl;
  idu1_out_t       alu_ctrl;
  logic [XLEN-1:0] alu_wb_data;
  logic [4:0]      alu_wb_rd_addr;
  logic            alu_wb_rd_wr_en;
  logic            pc_load;
  logic            busy;

  alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_ctrl         (in_ctrl),
    .alu_ctrl        (alu_ctrl),
    .alu_wb_data     (alu_wb_data),
    .alu_wb_rd_addr  (alu_wb_rd_addr),
    .alu_wb_rd_wr_en (alu_wb_rd_wr_en),
    .pc_load         (pc_load),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int issued = 0;
  int flushed = 0;

  // Accepted instructions not yet issued, in program order.
  idu1_out_t       exp_q[$];
  // Architectural registers as seen by program-order execution.
  logic [XLEN-1:0] model_rf [32];
  // Registers as already written back, i.e. what IDU1 reads.
  logic [XLEN-1:0] wb_rf [32];

  logic            pend_wb = 1'b0;
  logic [4:0]      pend_wb_addr = 5'd0;
  logic [XLEN-1:0] pend_wb_data = '0;
  logic            pend_br = 1'b0;
  logic            pend_taken = 1'b0;
  logic            br_wait_m;
  logic            prev_vld = 1'b0;
  logic [4:0]      prev_rd = 5'd0;

  task automatic checkOutput(input string name, input idu1_out_t act, input idu1_out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  function automatic logic headBlocked(input idu1_out_t h);
`ifdef ALU_ISSUE_FWD_EN
    return 1'b0;
`else
    return prev_vld && ((h.rs1_addr == prev_rd) || (h.rs2 && (h.rs2_addr == prev_rd)));
`endif
  endfunction

  // Behavioural ALU: replays results produced by the model one cycle after issue.
  initial begin
    alu_wb_rd_wr_en = 1'b0;
    alu_wb_rd_addr  = 5'd0;
    alu_wb_data     = '0;
    pc_load         = 1'b0;
    br_wait_m       = 1'b0;
    for (int r = 0; r < 32; r++) wb_rf[r] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        for (int r = 0; r < 32; r++) wb_rf[r] = '0;
        alu_wb_rd_wr_en = 1'b0;
        pc_load         = 1'b0;
        br_wait_m       = 1'b0;
      end else begin
        if (alu_wb_rd_wr_en && alu_wb_rd_addr != 5'd0) wb_rf[alu_wb_rd_addr] = alu_wb_data;
        alu_wb_rd_wr_en = pend_wb;
        alu_wb_rd_addr  = pend_wb_addr;
        alu_wb_data     = pend_wb_data;
        br_wait_m       = pend_br;
        pc_load         = pend_br && pend_taken;
      end
    end
  end

  // Monitor: decides from the model whether an issue is due and compares the control word.
  initial begin
    idu1_out_t       bubble;
    idu1_out_t       e;
    idu1_out_t       exp;
    logic [XLEN-1:0] a, b, res;
    logic            live;
    bubble     = '0;
    bubble.nop = 1'b1;
    for (int r = 0; r < 32; r++) model_rf[r] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("rst_bubble", alu_ctrl, bubble);
        exp_q.delete();
        pend_wb  = 1'b0;
        pend_br  = 1'b0;
        prev_vld = 1'b0;
        for (int r = 0; r < 32; r++) model_rf[r] = '0;
      end else begin
        checkBit("in_ready", in_ready, exp_q.size() < DEPTH);
        checkBit("busy", busy, (exp_q.size() != 0) || br_wait_m);
        pend_wb = 1'b0;
        pend_br = 1'b0;
        if (exp_q.size() > 0 && !br_wait_m && !headBlocked(exp_q[0])) begin
          e   = exp_q.pop_front();
          exp = e;
          exp.rs1_data = model_rf[e.rs1_addr];
          if (e.rs2) exp.rs2_data = model_rf[e.rs2_addr];
          checkOutput("issue", alu_ctrl, exp);
          issued++;
          a    = exp.rs1_data;
          b    = exp.rs2 ? exp.rs2_data : exp.imm;
          res  = exp.alu_op[0] ? (a ^ b) : (a + b);
          live = e.legal && e.alu && !e.nop;
          pend_wb      = live && e.rd;
          pend_wb_addr = e.rd_addr;
          pend_wb_data = res;
          if (pend_wb && e.rd_addr != 5'd0) model_rf[e.rd_addr] = res;
          pend_br    = live && (e.jal || e.condbr);
          pend_taken = e.jal || ((a == b) ^ e.alu_op[1]);
          prev_vld   = live && e.rd && (e.rd_addr != 5'd0);
          prev_rd    = e.rd_addr;
        end else begin
          checkOutput("bubble", alu_ctrl, bubble);
          prev_vld = 1'b0;
        end
        if (pc_load) begin
          flushed += exp_q.size();
          exp_q.delete();
        end
      end
    end
  end

  function automatic idu1_out_t randInstr();
    idu1_out_t t;
    int k;
    t          = '0;
    t.rs1_addr = 5'($urandom_range(0, 3));
    t.rs2_addr = 5'($urandom_range(0, 3));
    t.rs2      = ($urandom_range(0, 1) == 1);
    t.rs2_data = $urandom;
    t.imm      = $urandom;
    t.alu_op   = 4'($urandom_range(0, 3));
    t.rd_addr  = 5'($urandom_range(0, 3));
    t.rd       = ($urandom_range(0, 3) != 0);
    t.alu      = ($urandom_range(0, 9) != 0);
    t.legal    = ($urandom_range(0, 9) != 0);
    t.nop      = ($urandom_range(0, 15) == 0);
    k          = $urandom_range(0, 9);
    t.jal      = (k == 0);
    t.condbr   = (k == 1) || (k == 2);
    return t;
  endfunction

  function automatic idu1_out_t mkAlu(input logic [4:0] rs1a, input logic useRs2, input logic [4:0] rs2a,
                                      input logic [XLEN-1:0] imm, input logic [4:0] rda);
    idu1_out_t t;
    t          = '0;
    t.rs1_addr = rs1a;
    t.rs2      = useRs2;
    t.rs2_addr = rs2a;
    t.imm      = imm;
    t.rd       = 1'b1;
    t.rd_addr  = rda;
    t.alu      = 1'b1;
    t.legal    = 1'b1;
    return t;
  endfunction

  function automatic idu1_out_t mkBranch(input logic notEqual);
    idu1_out_t t;
    t           = '0;
    t.condbr    = 1'b1;
    t.rs2       = 1'b1;
    t.alu_op[1] = notEqual;
    t.alu       = 1'b1;
    t.legal     = 1'b1;
    return t;
  endfunction

  // Drives one cycle of IDU1 traffic; operands come from the written-back register view.
  task automatic applyStimulus(input logic vld, input idu1_out_t ins);
    idu1_out_t t;
    @(posedge clk);
    #2;
    t          = ins;
    t.rs1_data = wb_rf[t.rs1_addr];
    if (t.rs2) t.rs2_data = wb_rf[t.rs2_addr];
    in_valid = vld;
    in_ctrl  = t;
    @(negedge clk);
    #1;
    if (vld && in_ready && !rst && !pc_load) exp_q.push_back(t);
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic found;
    idu1_out_t t;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_ctrl  = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(1'b0, '0);

    // addi x1,x0,5 ; add x2,x1,x1 back-to-back
    applyStimulus(1'b1, mkAlu(5'd1 - 5'd1, 1'b0, 5'd0, 32'd5, 5'd1));
    applyStimulus(1'b1, mkAlu(5'd1, 1'b1, 5'd1, 32'd0, 5'd2));
    repeat (4) applyStimulus(1'b0, '0);

    // taken beq followed by younger entries, one arriving in the wait cycle
    applyStimulus(1'b1, mkBranch(1'b0));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, mkAlu(5'd2, 1'b0, 5'd0, 32'(i + 7), 5'd3));
    repeat (3) applyStimulus(1'b0, '0);

    // not-taken bne with one younger entry
    applyStimulus(1'b1, mkBranch(1'b1));
    applyStimulus(1'b1, mkAlu(5'd2, 1'b1, 5'd1, 32'd0, 5'd4));
    repeat (3) applyStimulus(1'b0, '0);

    // x3 written while a consumer waits behind a branch; x0 write must not reach an x0 reader
    applyStimulus(1'b1, mkAlu(5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 5'd3));
    applyStimulus(1'b1, mkBranch(1'b1));
    applyStimulus(1'b1, mkAlu(5'd3, 1'b0, 5'd0, 32'd0, 5'd5));
    applyStimulus(1'b1, mkAlu(5'd3, 1'b0, 5'd0, 32'd1, 5'd0));
    applyStimulus(1'b1, mkAlu(5'd0, 1'b0, 5'd0, 32'd0, 5'd6));
    repeat (4) applyStimulus(1'b0, '0);

    for (int c = 0; c < 3000; c++) applyStimulus($urandom_range(0, 4) != 0, randInstr());
    repeat (4) applyStimulus(1'b0, '0);

    // reset while the ALU is resolving a branch with entries queued
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      t = randInstr();
      if (c % 2 == 0) begin
        t.jal   = 1'b1;
        t.legal = 1'b1;
        t.alu   = 1'b1;
        t.nop   = 1'b0;
      end
      applyStimulus(1'b1, t);
      if (pend_br && exp_q.size() >= 1) found = 1'b1;
    end
    checkBit("brwait_setup", found, 1'b1);
    doReset();
    repeat (2) applyStimulus(1'b0, '0);
    applyStimulus(1'b1, mkAlu(5'd1, 1'b0, 5'd0, 32'd9, 5'd1));
    for (int c = 0; c < 500; c++) applyStimulus($urandom_range(0, 3) != 0, randInstr());
    repeat (4) applyStimulus(1'b0, '0);

    $display("[TB] issued %0d flushed %0d", issued, flushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
